// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_e : squash-tracking FSM states (run / squash pending)
//   cause_e : stall_cause encoding driven on the stall_cause output
//   CntWDefault / RdWDefault : default counter and register-index widths
package hazard_pkg;

  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StSquash = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    CauseNone   = 3'd0,
    CauseDstall = 3'd1,
    CauseRedir  = 3'd2,
    CauseLuse   = 3'd3,
    CauseIstall = 3'd4
  } cause_e;

  localparam int unsigned CntWDefault = 32;
  localparam int unsigned RdWDefault  = 5;

  // Load-use hit: EX holds a load to a non-zero register that ID actually reads.
  function automatic logic load_use_hit(input logic       memread,
                                        input logic       rd_nonzero,
                                        input logic       rs1_match,
                                        input logic       use_rs1,
                                        input logic       rs2_match,
                                        input logic       use_rs2);
    return memread && rd_nonzero && ((rs1_match && use_rs1) || (rs2_match && use_rs2));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-side requests in, register enables/flushes out.
//   master : pipeline side (drives rs/rd/memread/redirect/cache stalls, reads controls)
//   slave  : hazard_ctrl (reads requests, drives writes, flushes and stall_cause)
interface hazard_ctrl_if #(
  parameter int unsigned RD_W = 5
);
  logic [RD_W-1:0] IF_ID_rs1;
  logic [RD_W-1:0] IF_ID_rs2;
  logic            IF_ID_use_rs1;
  logic            IF_ID_use_rs2;
  logic [RD_W-1:0] ID_EX_rd;
  logic            ID_EX_memread;
  logic            ex_redirect;
  logic            icache_stall;
  logic            dcache_stall;

  logic            pc_write;
  logic            IF_ID_write;
  logic            ID_EX_write;
  logic            EX_MEM_write;
  logic            MEM_WB_write;
  logic            IF_ID_flush;
  logic            ID_EX_flush;
  logic [2:0]      stall_cause;

  modport master (
    output IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2, ID_EX_rd, ID_EX_memread,
           ex_redirect, icache_stall, dcache_stall,
    input  pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
           IF_ID_flush, ID_EX_flush, stall_cause
  );

  modport slave (
    input  IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2, ID_EX_rd, ID_EX_memread,
           ex_redirect, icache_stall, dcache_stall,
    output pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
           IF_ID_flush, ID_EX_flush, stall_cause
  );
endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter: increments on en_i, sticks at all-ones.
//   clk, rst : clock and asynchronous active-high reset (clears to 0)
//   en_i     : count this cycle
//   cnt_o    : current count
module hazard_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller. Arbitrates dcache stall, EX redirect,
// load-use and icache stall (in that priority) into PC / pipeline-register
// enables and flushes, and remembers a wrong-path fetch that must be squashed
// when a redirect overlaps an icache miss.
//   clk, rst : clock, asynchronous active-high reset
//   hz       : hazard_ctrl_if slave (requests in, controls out)
//   perf_*   : saturating per-cause win counters, only with HAZARD_PERF_EN defined
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned RD_W  = RdWDefault,
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic              clk,
  input  logic              rst,
  hazard_ctrl_if.slave      hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_dstall,
  output logic [CNT_W-1:0]  perf_istall,
  output logic [CNT_W-1:0]  perf_luse,
  output logic [CNT_W-1:0]  perf_redir
`endif
);

  state_e state_q, state_d;

  logic [RD_W-1:0] ex_rd;
  logic            load_use;
  logic            squash_exit;

  logic   pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic   if_id_flush, id_ex_flush;
  cause_e cause;

  assign ex_rd = hz.ID_EX_rd;

  assign load_use = load_use_hit(hz.ID_EX_memread, ex_rd != '0,
                                 ex_rd == hz.IF_ID_rs1, hz.IF_ID_use_rs1,
                                 ex_rd == hz.IF_ID_rs2, hz.IF_ID_use_rs2);

  // First cycle the wrong-path fetch lands with nothing holding the pipe.
  assign squash_exit = (state_q == StSquash) && !hz.icache_stall && !hz.dcache_stall;

  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    cause        = CauseNone;

    if (hz.dcache_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      cause        = CauseDstall;
    end else if (hz.ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      cause       = CauseRedir;
      // An outstanding fetch is wrong-path; it must be dropped when it returns.
      state_d     = hz.icache_stall ? StSquash : StRun;
    end else if (squash_exit) begin
      // Load-use is deliberately not considered: ID is being discarded.
      if_id_flush = 1'b1;
      cause       = CauseRedir;
      state_d     = StRun;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      cause       = CauseLuse;
    end else if (hz.icache_stall) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      cause       = CauseIstall;
    end

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      cause        = CauseNone;
      state_d      = StRun;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.IF_ID_write  = if_id_write;
  assign hz.ID_EX_write  = id_ex_write;
  assign hz.EX_MEM_write = ex_mem_write;
  assign hz.MEM_WB_write = mem_wb_write;
  assign hz.IF_ID_flush  = if_id_flush;
  assign hz.ID_EX_flush  = id_ex_flush;
  assign hz.stall_cause  = cause;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_dstall (
    .clk   (clk),
    .rst   (rst),
    .en_i  (cause == CauseDstall),
    .cnt_o (perf_dstall)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_istall (
    .clk   (clk),
    .rst   (rst),
    .en_i  (cause == CauseIstall),
    .cnt_o (perf_istall)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_luse (
    .clk   (clk),
    .rst   (rst),
    .en_i  (cause == CauseLuse),
    .cnt_o (perf_luse)
  );

  // Squash-exit cycles report CauseRedir, so they land here as well.
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_redir (
    .clk   (clk),
    .rst   (rst),
    .en_i  (cause == CauseRedir),
    .cnt_o (perf_redir)
  );
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// stimulus against a table-driven priority model. Perf counters are checked
// when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;

  localparam int unsigned TbCntW = 8;
  localparam int          CntMax = (1 << TbCntW) - 1;

  // {pc, IF_ID_w, ID_EX_w, EX_MEM_w, MEM_WB_w, IF_ID_flush, ID_EX_flush, cause[2:0]}
  localparam logic [9:0] VecReset  = 10'b00000_11_000;
  localparam logic [9:0] VecDstall = 10'b00000_00_001;
  localparam logic [9:0] VecRedir  = 10'b11111_11_010;
  localparam logic [9:0] VecSqExit = 10'b11111_10_010;
  localparam logic [9:0] VecLuse   = 10'b00111_01_011;
  localparam logic [9:0] VecIstall = 10'b01111_10_100;
  localparam logic [9:0] VecNone   = 10'b11111_00_000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.RD_W(5)) hz ();

`ifdef HAZARD_PERF_EN
  logic [TbCntW-1:0] perf_dstall, perf_istall, perf_luse, perf_redir;
`endif

  hazard_ctrl #(.RD_W(5), .CNT_W(TbCntW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
`ifdef HAZARD_PERF_EN
    ,
    .perf_dstall (perf_dstall),
    .perf_istall (perf_istall),
    .perf_luse   (perf_luse),
    .perf_redir  (perf_redir)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model state: wrong-path fetch pending, and per-cause win counts.
  logic pend = 1'b0;
  int   m_cnt [5];

  function automatic logic [9:0] dut_vec();
    return {hz.pc_write, hz.IF_ID_write, hz.ID_EX_write, hz.EX_MEM_write, hz.MEM_WB_write,
            hz.IF_ID_flush, hz.ID_EX_flush, hz.stall_cause};
  endfunction

  function automatic logic model_hit();
    logic [4:0] src [2];
    logic       used [2];
    logic       hit;
    src[0] = hz.IF_ID_rs1;  used[0] = hz.IF_ID_use_rs1;
    src[1] = hz.IF_ID_rs2;  used[1] = hz.IF_ID_use_rs2;
    hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (used[i] && src[i] == hz.ID_EX_rd) hit = 1'b1;
    end
    return hit && hz.ID_EX_memread && (hz.ID_EX_rd != 5'd0);
  endfunction

  function automatic logic [9:0] model_vec();
    if (rst)                        return VecReset;
    if (hz.dcache_stall)            return VecDstall;
    if (hz.ex_redirect)             return VecRedir;
    if (pend && !hz.icache_stall)   return VecSqExit;
    if (model_hit())                return VecLuse;
    if (hz.icache_stall)            return VecIstall;
    return VecNone;
  endfunction

  task automatic clear_model();
    pend = 1'b0;
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied, then clock.
  task automatic tick();
    logic [9:0] e;
    int         c;
    e = model_vec();
    c = int'(e[2:0]);
    if (!rst) begin
      if (c != 0 && m_cnt[c] < CntMax) m_cnt[c]++;
      if (hz.dcache_stall)      pend = pend;
      else if (hz.ex_redirect)  pend = hz.icache_stall;
      else if (!hz.icache_stall) pend = 1'b0;
    end else begin
      pend = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic mr,
                       input logic rdr, input logic ic, input logic dc);
    @(negedge clk);
    hz.IF_ID_rs1     = rs1;
    hz.IF_ID_rs2     = rs2;
    hz.IF_ID_use_rs1 = u1;
    hz.IF_ID_use_rs2 = u2;
    hz.ID_EX_rd      = rd;
    hz.ID_EX_memread = mr;
    hz.ex_redirect   = rdr;
    hz.icache_stall  = ic;
    hz.dcache_stall  = dc;
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [9:0] got;
    idle();
    rst = 1'b1;
    #1;
    got = dut_vec();
    checks++;
    if (got !== VecReset) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", got, VecReset);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    idle();
    got = dut_vec();
    checks++;
    if (got !== VecNone) begin
      errors++;
      $display("FAIL after_reset_idle got=%b exp=%b", got, VecNone);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [9:0] got, exp;
    // Load x5 in EX, ID reads x5 via rs2.
    drive(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    got = dut_vec(); exp = model_vec();
    checks++;
    if (got !== VecLuse || got !== exp) begin
      errors++;
      $display("FAIL load_use_rs2 got=%b exp=%b", got, VecLuse);
    end
    tick();
    // Bubble now in EX, load moved to MEM: no second stall.
    drive(5'd1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    got = dut_vec();
    checks++;
    if (got !== VecNone) begin
      errors++;
      $display("FAIL load_use_one_bubble got=%b exp=%b", got, VecNone);
    end
    tick();
    // Load to x0 never stalls.
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    got = dut_vec();
    checks++;
    if (got !== VecNone) begin
      errors++;
      $display("FAIL load_use_x0 got=%b exp=%b", got, VecNone);
    end
    tick();
    // Matching rs1 that is not actually read.
    drive(5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    got = dut_vec();
    checks++;
    if (got !== VecNone) begin
      errors++;
      $display("FAIL load_use_unused_rs1 got=%b exp=%b", got, VecNone);
    end
    tick();
    // Load-use outranks an icache stall.
    drive(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    got = dut_vec();
    checks++;
    if (got !== VecLuse) begin
      errors++;
      $display("FAIL load_use_over_istall got=%b exp=%b", got, VecLuse);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_squash();
    logic [9:0] got, exp;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    got = dut_vec();
    checks++;
    if (got !== VecRedir) begin
      errors++;
      $display("FAIL squash_redirect got=%b exp=%b", got, VecRedir);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      got = dut_vec(); exp = model_vec();
      checks++;
      if (got !== VecIstall || got !== exp) begin
        errors++;
        $display("FAIL squash_hold[%0d] got=%b exp=%b", i, got, VecIstall);
      end
      tick();
    end
    idle();
    got = dut_vec();
    checks++;
    if (got !== VecSqExit) begin
      errors++;
      $display("FAIL squash_exit got=%b exp=%b", got, VecSqExit);
    end
    tick();
    idle();
    got = dut_vec();
    checks++;
    if (got !== VecNone) begin
      errors++;
      $display("FAIL squash_back_to_run got=%b exp=%b", got, VecNone);
    end
    tick();
  endtask

  task automatic test_dcache_overlap();
    logic [9:0] got;
    for (int i = 0; i < 3; i++) begin
      drive(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
      got = dut_vec();
      checks++;
      if (got !== VecDstall) begin
        errors++;
        $display("FAIL dcache_freeze[%0d] got=%b exp=%b", i, got, VecDstall);
      end
      tick();
    end
    drive(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    got = dut_vec();
    checks++;
    if (got !== VecRedir) begin
      errors++;
      $display("FAIL dcache_then_redirect got=%b exp=%b", got, VecRedir);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_async_reset_squash();
    logic [9:0] got;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    got = dut_vec();
    checks++;
    if (got !== VecReset) begin
      errors++;
      $display("FAIL async_reset_outputs got=%b exp=%b", got, VecReset);
    end
    clear_model();
`ifdef HAZARD_PERF_EN
    checks++;
    if ({perf_dstall, perf_istall, perf_luse, perf_redir} !== '0) begin
      errors++;
      $display("FAIL async_reset_counters got=%h exp=0",
               {perf_dstall, perf_istall, perf_luse, perf_redir});
    end
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Fetch returns after reset: must not be treated as a squash exit.
    idle();
    got = dut_vec();
    checks++;
    if (got !== VecNone) begin
      errors++;
      $display("FAIL async_reset_to_run got=%b exp=%b", got, VecNone);
    end
    tick();
  endtask

  task automatic test_random();
    logic [9:0] got, exp;
    for (int n = 0; n < 600; n++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 6) == 0));
      got = dut_vec();
      exp = model_vec();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d] got=%b exp=%b pend=%0b", n, got, exp, pend);
      end
      tick();
    end
`ifdef HAZARD_PERF_EN
    @(negedge clk);
    #1;
    checks++;
    if (int'(perf_dstall) != m_cnt[1] || int'(perf_redir) != m_cnt[2] ||
        int'(perf_luse) != m_cnt[3] || int'(perf_istall) != m_cnt[4]) begin
      errors++;
      $display("FAIL random_counters got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
               perf_dstall, perf_redir, perf_luse, perf_istall,
               m_cnt[1], m_cnt[2], m_cnt[3], m_cnt[4]);
    end
`endif
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    @(negedge clk);
    rst = 1'b1;
    idle();
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      tick();
    end
    @(negedge clk);
    #1;
    checks++;
    if (perf_dstall !== 8'd10) begin
      errors++;
      $display("FAIL perf_dstall got=%0d exp=10", perf_dstall);
    end
    checks++;
    if (perf_luse !== 8'd2 || perf_redir !== 8'd0 || perf_istall !== 8'd0) begin
      errors++;
      $display("FAIL perf_luse got=%0d/%0d/%0d exp=2/0/0", perf_luse, perf_redir, perf_istall);
    end
    for (int i = 0; i < 300; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    @(negedge clk);
    #1;
    checks++;
    if (perf_dstall !== 8'hff) begin
      errors++;
      $display("FAIL perf_saturate got=%0d exp=255", perf_dstall);
    end
    idle();
    tick();
  endtask
`endif

  initial begin
    clear_model();
    test_reset();
    test_load_use();
    test_squash();
    test_dcache_overlap();
    test_async_reset_squash();
    test_random();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core. Each cycle it arbitrates the stall and flush requests from the data cache, EX-stage branch/jalr redirect, load-use detection and the instruction cache. It drives the write-enable and flush controls of the PC and the four pipeline registers. A small FSM records a pending squash when a redirect overlaps an outstanding I-cache miss. Optional per-cause performance counters are included.

## Interface
- `RD_W`, default 5: register index width.
- `CNT_W`, default 32: performance counter width.
- `clk` in 1: core clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `IF_ID_rs1`, `IF_ID_rs2` in RD_W: source registers of the instruction in ID.
- `IF_ID_use_rs1`, `IF_ID_use_rs2` in 1: the ID instruction actually reads that source.
- `ID_EX_rd` in RD_W: destination of the instruction in EX.
- `ID_EX_memread` in 1: the EX instruction is a load.
- `ex_redirect` in 1: a taken branch or jalr resolved in EX; the PC mux selects the target.
- `icache_stall`, `dcache_stall` in 1: cache miss in progress.
- `pc_write`, `IF_ID_write`, `ID_EX_write`, `EX_MEM_write`, `MEM_WB_write` out 1: register enables.
- `IF_ID_flush`, `ID_EX_flush` out 1: load NOP/bubble on the next edge.
- `stall_cause` out 3: the winning cause, encoded per `hazard_pkg`.
- `perf_dstall`, `perf_istall`, `perf_luse`, `perf_redir` out CNT_W: present only with the macro.

## Operation
- Control outputs are combinational from the inputs and the FSM state.
- FSM states: RUN, SQUASH.
- Priority, highest first:
  - dcache_stall: every `*_write`=0 and both flushes=0; whole pipe frozen. cause=DSTALL.
  - ex_redirect: pc_write=1, IF_ID_flush=1, ID_EX_flush=1, other writes=1. cause=REDIR.
    - If icache_stall=1 in the same cycle, go to SQUASH, because the in-flight fetch is wrong-path.
  - load-use: detected when ID_EX_memread=1, ID_EX_rd≠0, and (rd==IF_ID_rs1 with use_rs1, or rd==IF_ID_rs2 with use_rs2).
    - Action: pc_write=0, IF_ID_write=0, ID_EX_flush=1, EX_MEM/MEM_WB advance. cause=LUSE.
    - Exactly one bubble per hazard; the next cycle re-evaluates with the load now in MEM.
  - icache_stall: pc_write=0, IF_ID_flush=1 (bubble into ID), downstream advances. cause=ISTALL.
  - none: all writes=1, flushes=0, cause=NONE.
- SQUASH:
  - While icache_stall=1, behave as above and stay in SQUASH.
  - First cycle with icache_stall=0 and dcache_stall=0: force IF_ID_flush=1 (discard the wrong-path word) and pc_write=1, then return to RUN.
  - dcache_stall in SQUASH: freeze and hold the state.
  - A new ex_redirect in SQUASH stays in SQUASH while icache_stall=1. Otherwise the redirect flush and the squash flush coincide and the FSM returns to RUN.
- Load-use is suppressed on the squash-exit cycle, because the ID contents are being flushed.

## Timing
- Zero-cycle decision: outputs are valid in the same cycle as the inputs.
- FSM transitions happen on the next clk edge.
- Reset (asynchronous, also mid-miss):
  - State goes to RUN and counters clear to 0.
  - While rst=1: all `*_write`=0, IF_ID_flush=1, ID_EX_flush=1, stall_cause=NONE.
- Redirect latency: target fetched the cycle after ex_redirect. Two flushed slots, plus one more if a squash was pending.
- Load-use penalty: exactly 1 cycle. D-cache miss penalty: equal to the dcache_stall duration.

## Configuration
- `HAZARD_PERF_EN` defined:
  - Four saturating CNT_W counters, each incremented on every cycle its cause wins: DSTALL, ISTALL, LUSE, REDIR.
  - SQUASH-exit cycles count as REDIR.
  - Counters saturate at all-ones.
- `HAZARD_PERF_EN` undefined: perf ports and counters are absent; control behaviour is identical.

## Structure
- `hazard_pkg` holds:
  - the FSM state enum {RUN, SQUASH};
  - the stall_cause encoding: NONE=0, DSTALL=1, REDIR=2, LUSE=3, ISTALL=4;
  - the default CNT_W.
- Sub-module `hazard_perf_cnt`: one saturating counter with an enable. It is instantiated four times under `HAZARD_PERF_EN`.

## Test plan
- Load x5 in EX, ID reads x5 as rs2 with use_rs2=1 -> 1 cycle of pc_write=0, IF_ID_write=0, ID_EX_flush=1, cause=3. Same with rd=x0 -> no stall.
- ex_redirect with icache_stall=1 for 4 cycles -> SQUASH entered; on the cycle icache_stall falls, IF_ID_flush=1 and the state returns to RUN.
- dcache_stall for 3 cycles overlapping ex_redirect and load-use -> all writes 0 for 3 cycles. The redirect then wins on the 4th cycle (cause=2).
- rst pulsed while in SQUASH -> asynchronous return to RUN, all writes 0 and both flushes 1 during reset, counters 0.
- With `HAZARD_PERF_EN`: 10 dcache stall cycles and 2 load-use hazards -> perf_dstall=10, perf_luse=2. A counter preloaded near all-ones saturates at all-ones.
